riscv_regfile_sb: RTL and testbench
===================================

# riscv_regfile_sb

Parametrised integer register file with a per-register busy scoreboard, N combinational read ports, one writeback port with optional same-cycle bypass, and a sequential post-reset clear sweep. It sits between decode/issue (reads, destination reservation) and writeback in the core pipeline. It is the storage and hazard source for the issue stage.

## Interface

- XLEN, 32: register width in bits.
- NREGS, 32: register count, power of two, ≥ 4; AW = $clog2(NREGS).
- NREAD, 2: number of read ports, ≥ 1.
- BYPASS, 1: 1 forwards a same-cycle writeback to the read ports; 0 disables forwarding.

- clk_in  in  1  clock; all state changes on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- ready_out  out  1  high once the clear sweep has finished; reset value 0.
- ra_in  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rdata_out  out  NREAD*XLEN  read data for port k.
- rbusy_out  out  NREAD  port k's source register has a pending write.
- issue_valid_in  in  1  reserve destination issue_rd_in.
- issue_rd_in  in  AW  destination register to mark busy.
- wb_valid_in  in  1  writeback strobe.
- wb_rd_in  in  AW  writeback destination.
- wb_data_in  in  XLEN  writeback data.
- busy_out  out  NREGS  scoreboard vector; bit 0 is always 0; reset value 0.
- dbg_addr_in  in  AW  debug read address.
- dbg_data_out  out  XLEN  debug read data (array contents, no bypass).

## Operation

- State machine has two states: CLEAR and READY.
- Reset:
  - rst_in high at an edge: state ← CLEAR, idx ← 1, busy ← 0. No array write occurs that cycle.
  - rst_in is honoured in every state, including mid-sweep; the sweep restarts at idx 1.
- CLEAR:
  - Each edge with rst_in low writes reg[idx] ← 0 and increments idx.
  - The edge that writes idx = NREGS−1 moves the state to READY.
  - issue_valid_in and wb_valid_in are ignored.
  - rdata_out, rbusy_out and dbg_data_out read 0.
- READY:
  - Issue: issue_valid_in with issue_rd_in ≠ 0 sets busy[issue_rd_in].
  - Writeback: wb_valid_in with wb_rd_in ≠ 0 writes reg[wb_rd_in] ← wb_data_in and clears busy[wb_rd_in].
  - Register 0 is never written and never busy. Any read of address 0 returns 0 with rbusy 0.
  - Issue and writeback to the same register on the same edge: data is written, and busy ends at 1 (issue wins).
  - Issue and writeback to different registers on the same edge: both take effect.
  - A writeback to a non-busy register is legal: data is written and busy stays 0.
- Read port k (combinational):
  - BYPASS = 1, wb_valid_in, wb_rd_in = ra_k ≠ 0: rdata = wb_data_in, rbusy = 0.
  - Otherwise: rdata = reg[ra_k], rbusy = busy[ra_k].
  - A same-cycle issue to ra_k does not affect that cycle's rbusy.
- All read ports are independent; duplicate addresses across ports are legal.

## Timing

- Reads, bypass and debug reads: zero latency (combinational from addresses and wb inputs).
- Writes and busy updates: visible at the outputs the cycle after the edge.
- ready_out rises NREGS−1 edges after the first edge with rst_in low; NREGS = 32 gives 31 edges.
- busy_out is 0 from the reset edge onward until the first issue in READY.
- Array contents after a mid-operation reset: undefined until the sweep writes them. Outputs still read 0 while in CLEAR.

## Test plan

- Reset sweep: hold rst_in 3 cycles, release; ready_out = 0 for 31 edges, then 1. Read all 32 registers; every one returns 0.
- Write/read: write x5 ← 0xDEADBEEF; next cycle ra port0 = 5 gives 0xDEADBEEF with rbusy 0. Write x0 ← 0x1234; reading x0 gives 0 and busy_out[0] = 0.
- Scoreboard: issue rd = 7; next cycle rbusy for x7 = 1 and busy_out = 0x80. Writeback x7 ← 0x55; the cycle after, rbusy = 0 and rdata = 0x55.
- Bypass and collision:
  - BYPASS = 1: wb x9 ← 0xA5A5 while port1 reads x9; same cycle rdata = 0xA5A5, rbusy = 0.
  - BYPASS = 0: the same stimulus returns the old value in that cycle.
  - Simultaneous issue and wb to x9: next cycle data = 0xA5A5 and busy[9] = 1.
- Mid-sweep reset: reassert rst_in at sweep idx 10; ready_out stays 0, and after release 31 more edges pass before ready_out = 1. Issue and wb presented during CLEAR leave busy_out = 0 and data unchanged.
- Parametrisation: XLEN = 64, NREGS = 16, NREAD = 3; ready_out rises after 15 edges. Three ports reading x3, x3 and x0 after x3 ← 0x0123456789ABCDEF return that value, that value, and 0.

Source files
------------

// File: rtl/riscv_regfile_sb.sv
// Integer register file with a per-register busy scoreboard, NREAD combinational
// read ports, one writeback port with optional bypass, and a post-reset clear sweep.
module riscv_regfile_sb #(
   parameter  int unsigned XLEN   = 32,
   parameter  int unsigned NREGS  = 32,
   parameter  int unsigned NREAD  = 2,
   parameter  int unsigned BYPASS = 1,
   localparam int unsigned AW     = $clog2(NREGS)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   output logic                     ready_out,
   input  logic [NREAD*AW-1:0]      ra_in,
   output logic [NREAD*XLEN-1:0]    rdata_out,
   output logic [NREAD-1:0]         rbusy_out,
   input  logic                     issue_valid_in,
   input  logic [AW-1:0]            issue_rd_in,
   input  logic                     wb_valid_in,
   input  logic [AW-1:0]            wb_rd_in,
   input  logic [XLEN-1:0]          wb_data_in,
   output logic [NREGS-1:0]         busy_out,
   input  logic [AW-1:0]            dbg_addr_in,
   output logic [XLEN-1:0]          dbg_data_out
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   logic              we;
   logic [AW-1:0]     waddr;
   logic [XLEN-1:0]   wdata;
   logic [XLEN-1:0]   regs [NREGS];
   logic [AW-1:0]     ra;

   // State, sweep index and scoreboard registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_CLEAR;
         idx_q   <= AW'(1);
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, scoreboard update and array write selection
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      we      = 1'b0;
      waddr   = wb_rd_in;
      wdata   = wb_data_in;
      case (state_q)
         S_CLEAR: begin
            we    = 1'b1;
            waddr = idx_q;
            wdata = '0;
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST_IDX) state_d = S_READY;
         end
         S_READY: begin
            if (wb_valid_in && (wb_rd_in != '0)) begin
               we               = 1'b1;
               busy_d[wb_rd_in] = 1'b0;
            end
            // issue applied last so it wins a same-register collision
            if (issue_valid_in && (issue_rd_in != '0)) busy_d[issue_rd_in] = 1'b1;
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // Storage array; x0 is never written and is masked on every read path
   always_ff @(posedge clk_in) begin
      if (we && !rst_in) regs[waddr] <= wdata;
   end

   // Read ports with optional same-cycle writeback forwarding
   always_comb begin
      rdata_out = '0;
      rbusy_out = '0;
      ra        = '0;
      for (int unsigned k = 0; k < NREAD; k++) begin
         ra = ra_in[k*AW +: AW];
         if ((state_q == S_READY) && (ra != '0)) begin
            if ((BYPASS != 0) && wb_valid_in && (wb_rd_in == ra)) begin
               rdata_out[k*XLEN +: XLEN] = wb_data_in;
            end else begin
               rdata_out[k*XLEN +: XLEN] = regs[ra];
               rbusy_out[k]              = busy_q[ra];
            end
         end
      end
   end

   assign dbg_data_out = ((state_q == S_READY) && (dbg_addr_in != '0)) ? regs[dbg_addr_in] : '0;
   assign busy_out     = busy_q;
   assign ready_out    = (state_q == S_READY);

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb: two 32x32 instances (bypass on/off) sharing
// stimulus, plus a 64-bit, 16-entry, 3-port instance.
module tb_riscv_regfile_sb;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [9:0]  ra;
   logic [63:0] rdata_a, rdata_b;
   logic [1:0]  rbusy_a, rbusy_b;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] busy_a, busy_b;
   logic        ready_a, ready_b;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_a, dbg_b;

   logic         rst_c;
   logic [11:0]  ra_c;
   logic [191:0] rdata_c;
   logic [2:0]   rbusy_c;
   logic         iv_c;
   logic [3:0]   ird_c;
   logic         wv_c;
   logic [3:0]   wrd_c;
   logic [63:0]  wd_c;
   logic [15:0]  busy_c;
   logic         ready_c;
   logic [3:0]   dbga_c;
   logic [63:0]  dbgd_c;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk_in = ~clk_in;

   riscv_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (
      .clk_in(clk_in), .rst_in(rst_in), .ready_out(ready_a), .ra_in(ra),
      .rdata_out(rdata_a), .rbusy_out(rbusy_a), .issue_valid_in(issue_valid),
      .issue_rd_in(issue_rd), .wb_valid_in(wb_valid), .wb_rd_in(wb_rd),
      .wb_data_in(wb_data), .busy_out(busy_a), .dbg_addr_in(dbg_addr), .dbg_data_out(dbg_a));

   riscv_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (
      .clk_in(clk_in), .rst_in(rst_in), .ready_out(ready_b), .ra_in(ra),
      .rdata_out(rdata_b), .rbusy_out(rbusy_b), .issue_valid_in(issue_valid),
      .issue_rd_in(issue_rd), .wb_valid_in(wb_valid), .wb_rd_in(wb_rd),
      .wb_data_in(wb_data), .busy_out(busy_b), .dbg_addr_in(dbg_addr), .dbg_data_out(dbg_b));

   riscv_regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1)) dut_c (
      .clk_in(clk_in), .rst_in(rst_c), .ready_out(ready_c), .ra_in(ra_c),
      .rdata_out(rdata_c), .rbusy_out(rbusy_c), .issue_valid_in(iv_c),
      .issue_rd_in(ird_c), .wb_valid_in(wv_c), .wb_rd_in(wrd_c),
      .wb_data_in(wd_c), .busy_out(busy_c), .dbg_addr_in(dbga_c), .dbg_data_out(dbgd_c));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      rst_in = 1'b1; ra = '0; issue_valid = 1'b0; issue_rd = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; dbg_addr = '0;
      rst_c = 1'b1; ra_c = '0; iv_c = 1'b0; ird_c = '0; wv_c = 1'b0;
      wrd_c = '0; wd_c = '0; dbga_c = '0;

      // reset held three edges
      repeat (3) tick();
      chk("rst_ready", 64'(ready_a), 64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_rdata", rdata_a, 64'd0);

      // sweep: ready after 31 edges
      rst_in = 1'b0;
      n = 0;
      while (ready_a !== 1'b1 && n < 100) begin tick(); n++; end
      chk("sweep_edges", 64'(n), 64'd31);
      chk("sweep_ready_b", 64'(ready_b), 64'd1);
      for (int i = 0; i < 32; i++) begin
         ra = {5'd0, 5'(i)}; dbg_addr = 5'(i);
         #1;
         chk($sformatf("sweep_x%0d", i), rdata_a[31:0], 64'd0);
         chk($sformatf("sweep_dbg_x%0d", i), 64'(dbg_a), 64'd0);
      end

      // write x5 then read it back
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      tick();
      wb_valid = 1'b0; ra = {5'd0, 5'd5}; dbg_addr = 5'd5;
      #1;
      chk("x5_rdata", rdata_a[31:0], 64'hDEADBEEF);
      chk("x5_rbusy", 64'(rbusy_a[0]), 64'd0);
      chk("x5_dbg_b", 64'(dbg_b), 64'hDEADBEEF);

      // write x0 is dropped
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
      tick();
      wb_valid = 1'b0; ra = {5'd0, 5'd0}; dbg_addr = 5'd0;
      #1;
      chk("x0_rdata", rdata_a[31:0], 64'd0);
      chk("x0_dbg", 64'(dbg_a), 64'd0);
      chk("x0_busy", 64'(busy_a[0]), 64'd0);

      // scoreboard: issue x7, same-cycle rbusy unaffected
      issue_valid = 1'b1; issue_rd = 5'd7; ra = {5'd7, 5'd0};
      #1;
      chk("x7_issue_same", 64'(rbusy_a[1]), 64'd0);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("x7_rbusy", 64'(rbusy_a[1]), 64'd1);
      chk("x7_busy_vec", 64'(busy_a), 64'h80);
      chk("x7_busy_vec_b", 64'(busy_b), 64'h80);

      // writeback x7: bypass on forwards, bypass off sees old value and busy
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
      #1;
      chk("x7_byp_a_data", rdata_a[63:32], 64'h55);
      chk("x7_byp_a_busy", 64'(rbusy_a[1]), 64'd0);
      chk("x7_nobyp_b_data", rdata_b[63:32], 64'd0);
      chk("x7_nobyp_b_busy", 64'(rbusy_b[1]), 64'd1);
      tick();
      wb_valid = 1'b0;
      #1;
      chk("x7_wb_data", rdata_a[63:32], 64'h55);
      chk("x7_wb_rbusy", 64'(rbusy_a[1]), 64'd0);
      chk("x7_wb_busy_vec", 64'(busy_a), 64'd0);

      // x9: old value, then wb + issue collision with port1 reading x9
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1111;
      tick();
      wb_data = 32'hA5A5; issue_valid = 1'b1; issue_rd = 5'd9; ra = {5'd9, 5'd0};
      #1;
      chk("x9_byp_a_data", rdata_a[63:32], 64'hA5A5);
      chk("x9_byp_a_busy", 64'(rbusy_a[1]), 64'd0);
      chk("x9_nobyp_b_data", rdata_b[63:32], 64'h1111);
      tick();
      wb_valid = 1'b0; issue_valid = 1'b0;
      #1;
      chk("x9_coll_data", rdata_a[63:32], 64'hA5A5);
      chk("x9_coll_rbusy", 64'(rbusy_a[1]), 64'd1);
      chk("x9_coll_busy_vec", 64'(busy_a), 64'h200);
      chk("x9_coll_b_data", rdata_b[63:32], 64'hA5A5);

      // issue x3 and wb x9 on the same edge; debug read bypasses nothing
      issue_valid = 1'b1; issue_rd = 5'd3; wb_valid = 1'b1; wb_rd = 5'd9;
      wb_data = 32'h77; dbg_addr = 5'd9;
      #1;
      chk("x9_dbg_nobyp", 64'(dbg_a), 64'hA5A5);
      tick();
      issue_valid = 1'b0; wb_valid = 1'b0;
      #1;
      chk("diff_busy_vec", 64'(busy_a), 64'h8);
      chk("diff_x9_data", rdata_a[63:32], 64'h77);

      // wb to non-busy x12 with issue to x0
      wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hC; issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      wb_valid = 1'b0; issue_valid = 1'b0; dbg_addr = 5'd12;
      #1;
      chk("x12_busy_vec", 64'(busy_a), 64'h8);
      chk("x12_dbg", 64'(dbg_a), 64'hC);

      // mid-sweep reset with issue/wb presented during CLEAR
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0; ra = {5'd0, 5'd5};
      #1;
      chk("clr_busy", 64'(busy_a), 64'd0);
      chk("clr_rdata_mask", rdata_a[31:0], 64'd0);
      chk("clr_ready", 64'(ready_a), 64'd0);
      issue_valid = 1'b1; issue_rd = 5'd4; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hFFFF;
      repeat (9) tick();
      chk("mid_ready", 64'(ready_a), 64'd0);
      chk("mid_busy", 64'(busy_a), 64'd0);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      n = 0;
      while (ready_a !== 1'b1 && n < 100) begin tick(); n++; end
      issue_valid = 1'b0; wb_valid = 1'b0;
      #1;
      chk("resweep_edges", 64'(n), 64'd31);
      chk("resweep_busy", 64'(busy_a), 64'd0);
      chk("resweep_x5", rdata_a[31:0], 64'd0);

      // wide, shallow, three-port instance
      rst_c = 1'b0;
      n = 0;
      while (ready_c !== 1'b1 && n < 100) begin tick(); n++; end
      chk("c_sweep_edges", 64'(n), 64'd15);
      wv_c = 1'b1; wrd_c = 4'd3; wd_c = 64'h0123456789ABCDEF;
      tick();
      wv_c = 1'b0; ra_c = {4'd0, 4'd3, 4'd3}; dbga_c = 4'd3;
      #1;
      chk("c_port0", rdata_c[63:0], 64'h0123456789ABCDEF);
      chk("c_port1", rdata_c[127:64], 64'h0123456789ABCDEF);
      chk("c_port2", rdata_c[191:128], 64'd0);
      chk("c_rbusy", 64'(rbusy_c), 64'd0);
      chk("c_dbg", dbgd_c, 64'h0123456789ABCDEF);
      chk("c_busy", 64'(busy_c), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
